// File: rtl/nand_reg_unit.sv
// WIDTH-bit hold/load/shift/increment register whose next-state, carry and
// mode-select logic is composed entirely of nand2 cells.

module nand2_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a & i_b);
endmodule

// Half adder: XOR from 4 nand2, AND from 2 nand2 (kept separate, not shared).
module nand_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  logic w_t, w_u, w_v, w_n;

  nand2_cell u_x0 (.i_a(i_a), .i_b(i_b), .o_y(w_t));
  nand2_cell u_x1 (.i_a(i_a), .i_b(w_t), .o_y(w_u));
  nand2_cell u_x2 (.i_a(i_b), .i_b(w_t), .o_y(w_v));
  nand2_cell u_x3 (.i_a(w_u), .i_b(w_v), .o_y(o_sum));

  nand2_cell u_a0 (.i_a(i_a), .i_b(i_b), .o_y(w_n));
  nand2_cell u_a1 (.i_a(w_n), .i_b(w_n), .o_y(o_carry));
endmodule

// 4:1 select tree: s0 picks within {hold,load} and {shift,incr}, s1 picks the pair.
module nand_mux4 (
  input  logic i_s0,
  input  logic i_ns0,
  input  logic i_s1,
  input  logic i_ns1,
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_d2,
  input  logic i_d3,
  output logic o_y
);
  logic w_a0, w_a1, w_lo, w_b0, w_b1, w_hi, w_c0, w_c1;

  nand2_cell u_l0 (.i_a(i_d0), .i_b(i_ns0), .o_y(w_a0));
  nand2_cell u_l1 (.i_a(i_d1), .i_b(i_s0),  .o_y(w_a1));
  nand2_cell u_l2 (.i_a(w_a0), .i_b(w_a1),  .o_y(w_lo));

  nand2_cell u_h0 (.i_a(i_d2), .i_b(i_ns0), .o_y(w_b0));
  nand2_cell u_h1 (.i_a(i_d3), .i_b(i_s0),  .o_y(w_b1));
  nand2_cell u_h2 (.i_a(w_b0), .i_b(w_b1),  .o_y(w_hi));

  nand2_cell u_o0 (.i_a(w_lo), .i_b(i_ns1), .o_y(w_c0));
  nand2_cell u_o1 (.i_a(w_hi), .i_b(i_s1),  .o_y(w_c1));
  nand2_cell u_o2 (.i_a(w_c0), .i_b(w_c1),  .o_y(o_y));
endmodule

module nand_reg_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             carry_out
);
  logic [WIDTH-1:0] r_q;
  logic             r_carry;

  logic             w_ns0_g, w_ns1_g, w_s0, w_s1, w_ns0, w_ns1;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_next;
  logic             w_carry_next;

  // Shared mode decode; gating with en turns every mode into hold (selects 00).
  nand2_cell u_g0 (.i_a(mode[0]), .i_b(en),      .o_y(w_ns0_g));
  nand2_cell u_g1 (.i_a(mode[1]), .i_b(en),      .o_y(w_ns1_g));
  nand2_cell u_g2 (.i_a(w_ns0_g), .i_b(w_ns0_g), .o_y(w_s0));
  nand2_cell u_g3 (.i_a(w_ns1_g), .i_b(w_ns1_g), .o_y(w_s1));
  nand2_cell u_g4 (.i_a(w_s0),    .i_b(w_s0),    .o_y(w_ns0));
  nand2_cell u_g5 (.i_a(w_s1),    .i_b(w_s1),    .o_y(w_ns1));

  assign w_c[0]   = 1'b1;
  assign w_shl[0] = ser_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      nand_half_adder u_ha (
        .i_a     (r_q[gi]),
        .i_b     (w_c[gi]),
        .o_sum   (w_inc[gi]),
        .o_carry (w_c[gi+1])
      );
      if (gi > 0) begin : g_shl
        assign w_shl[gi] = r_q[gi-1];
      end
      nand_mux4 u_mux (
        .i_s0  (w_s0),
        .i_ns0 (w_ns0),
        .i_s1  (w_s1),
        .i_ns1 (w_ns1),
        .i_d0  (r_q[gi]),
        .i_d1  (d[gi]),
        .i_d2  (w_shl[gi]),
        .i_d3  (w_inc[gi]),
        .o_y   (w_next[gi])
      );
    end
  endgenerate

  // Carry source: shifted-out MSB in shift, ripple carry-out (wrap) in increment.
  nand_mux4 u_cmux (
    .i_s0  (w_s0),
    .i_ns0 (w_ns0),
    .i_s1  (w_s1),
    .i_ns1 (w_ns1),
    .i_d0  (1'b0),
    .i_d1  (1'b0),
    .i_d2  (r_q[WIDTH-1]),
    .i_d3  (w_c[WIDTH]),
    .o_y   (w_carry_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else begin
      r_q     <= w_next;
      r_carry <= w_carry_next;
    end
  end

  assign q         = r_q;
  assign ser_out   = r_q[WIDTH-1];
  assign carry_out = r_carry;
endmodule

// File: tb/tb_nand_reg_unit.sv
// Directed + random scoreboard bench driving a 4-bit and an 8-bit unit in lockstep.

module tb_nand_reg_unit;
  logic       clk = 1'b0;
  logic       rst_n, en, ser_in;
  logic [1:0] mode;
  logic [7:0] d;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       so4, so8, co4, co8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] q4;
    logic       c4;
    logic [7:0] q8;
    logic       c8;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_q4;
  logic       m_c4;
  logic [7:0] m_q8;
  logic       m_c8;

  always #5 clk = ~clk;

  nand_reg_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[3:0]),
    .ser_in(ser_in), .q(q4), .ser_out(so4), .carry_out(co4)
  );

  nand_reg_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .ser_in(ser_in), .q(q8), .ser_out(so8), .carry_out(co8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic e, input logic [1:0] m,
                      input logic [7:0] dd, input logic si);
    exp_t x;
    @(negedge clk);
    rst_n = rn; en = e; mode = m; d = dd; ser_in = si;
    if (!rn) begin
      m_q4 = '0; m_c4 = 1'b0; m_q8 = '0; m_c8 = 1'b0;
    end else if (!e || m == 2'b00) begin
      m_c4 = 1'b0; m_c8 = 1'b0;
    end else if (m == 2'b01) begin
      m_q4 = dd[3:0]; m_c4 = 1'b0; m_q8 = dd; m_c8 = 1'b0;
    end else if (m == 2'b10) begin
      m_c4 = m_q4[3]; m_q4 = {m_q4[2:0], si};
      m_c8 = m_q8[7]; m_q8 = {m_q8[6:0], si};
    end else begin
      m_c4 = (m_q4 == 4'hF); m_q4 = m_q4 + 4'd1;
      m_c8 = (m_q8 == 8'hFF); m_q8 = m_q8 + 8'd1;
    end
    x.q4 = m_q4; x.c4 = m_c4; x.q8 = m_q8; x.c8 = m_c8;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty: observed 0 expected 1");
    end else begin
      x = sb.pop_front();
      chk("q4", {4'h0, q4}, {4'h0, x.q4});
      chk("carry4", {7'h0, co4}, {7'h0, x.c4});
      chk("serout4", {7'h0, so4}, {7'h0, x.q4[3]});
      chk("q8", q8, x.q8);
      chk("carry8", {7'h0, co8}, {7'h0, x.c8});
      chk("serout8", {7'h0, so8}, {7'h0, x.q8[7]});
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; ser_in = 1'b0;
    m_q4 = 'x; m_c4 = 'x; m_q8 = 'x; m_c8 = 'x;

    // reset priority over a load
    step(1'b0, 1'b1, 2'b01, 8'hAA, 1'b1);
    chk("t1_reset_q", {4'h0, q4}, 8'h00);

    // load then hold
    step(1'b1, 1'b1, 2'b01, 8'h09, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 8'h5A, 1'b1);
    chk("t2_hold_q", {4'h0, q4}, 8'h09);

    // increment wrap
    step(1'b1, 1'b1, 2'b01, 8'h0E, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t3_wrap_carry", {7'h0, co4}, 8'h01);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t3_after_wrap_q", {4'h0, q4}, 8'h01);

    // shift
    step(1'b1, 1'b1, 2'b01, 8'h0B, 1'b0);
    step(1'b1, 1'b1, 2'b10, 8'hFF, 1'b0);
    chk("t4_shift1_q", {4'h0, q4}, 8'h06);
    step(1'b1, 1'b1, 2'b10, 8'hFF, 1'b1);
    chk("t4_shift2_q", {4'h0, q4}, 8'h0D);

    // enable gating
    step(1'b1, 1'b1, 2'b01, 8'h03, 1'b0);
    step(1'b1, 1'b0, 2'b11, 8'h00, 1'b0);
    step(1'b1, 1'b0, 2'b11, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t5_gate_q", {4'h0, q4}, 8'h04);

    // reset mid-count
    step(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t6_count_q8", q8, 8'h05);
    step(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t6_restart_q8", q8, 8'h01);

    // 8-bit wrap and shift-out
    step(1'b1, 1'b1, 2'b01, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("t7_wrap8_carry", {7'h0, co8}, 8'h01);
    step(1'b1, 1'b1, 2'b01, 8'h81, 1'b0);
    step(1'b1, 1'b1, 2'b10, 8'h00, 1'b1);
    chk("t7_shift8_q", q8, 8'h03);

    // random mix
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
